// File: rtl/montgomery_mult.sv
// Radix-2 bit-serial Montgomery multiplier: mm_out = num_1 * num_2 * 2^-len mod modulus.
// Optional feature macro: MONT_MULT_FINAL_SUB_EN enables the final conditional subtraction.
module montgomery_mult (
    input  logic        clk,
    input  logic        rstn,
    input  logic        md_start,
    input  logic [7:0]  len,
    input  logic [31:0] num_1,
    input  logic [31:0] num_2,
    input  logic [31:0] modulus,
    output logic        md_end,
    output logic [31:0] mm_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] n_r;
    logic [33:0] s_r;
    logic [5:0]  cnt_r;
    logic [5:0]  len_eff_r;
    logic [5:0]  len_eff_s;

    // One Montgomery iteration; S < 2N keeps the 34-bit accumulator from overflowing.
    function automatic logic [33:0] mont_step(input logic [33:0] s, input logic a_bit,
                                              input logic [31:0] b, input logic [31:0] n);
        logic [33:0] t;
        t = s + (a_bit ? {2'b00, b} : 34'd0);
        if (t[0]) begin
            t = t + {2'b00, n};
        end else begin
            t = t;
        end
        return {1'b0, t[33:1]};
    endfunction

    // Reduce the accumulator into the output range.
    function automatic logic [31:0] mont_final(input logic [33:0] s, input logic [31:0] n);
        logic [33:0] r;
`ifdef MONT_MULT_FINAL_SUB_EN
        if (s >= {2'b00, n}) begin
            r = s - {2'b00, n};
        end else begin
            r = s;
        end
`else
        r = s;
`endif
        return r[31:0];
    endfunction

    // Clamp the requested length to the 32-bit datapath.
    always_comb begin
        if (len > 8'd32) begin
            len_eff_s = 6'd32;
        end else begin
            len_eff_s = len[5:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (md_start) begin
                    state_s = (len_eff_s == 6'd0) ? FIN : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == (len_eff_r - 6'd1)) begin
                    state_s = FIN;
                end else begin
                    state_s = CALC;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            n_r       <= 32'd0;
            s_r       <= 34'd0;
            cnt_r     <= 6'd0;
            len_eff_r <= 6'd0;
            md_end    <= 1'b0;
            mm_out    <= 32'd0;
        end else begin
            md_end <= (state_r == FIN);
            case (state_r)
                IDLE: begin
                    if (md_start) begin
                        a_r       <= num_1;
                        b_r       <= num_2;
                        n_r       <= modulus;
                        s_r       <= 34'd0;
                        cnt_r     <= 6'd0;
                        len_eff_r <= len_eff_s;
                    end
                end
                CALC: begin
                    // a_r is shifted so bit 0 is always the current multiplier bit
                    s_r   <= mont_step(s_r, a_r[0], b_r, n_r);
                    a_r   <= {1'b0, a_r[31:1]};
                    cnt_r <= cnt_r + 6'd1;
                end
                FIN: begin
                    mm_out <= mont_final(s_r, n_r);
                end
                default: begin
                    s_r <= 34'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_mult.sv
// Randomized self-checking bench for montgomery_mult against an arithmetic reference model.
module tb_montgomery_mult;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        md_start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic [31:0] num_1 = 32'd0;
    logic [31:0] num_2 = 32'd0;
    logic [31:0] modulus = 32'd1;
    logic        md_end;
    logic [31:0] mm_out;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned cyc     = 0;
    logic [31:0] held    = 32'd0;

    typedef struct {
        int unsigned when;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];

    montgomery_mult dut (
        .clk      (clk),
        .rstn     (rstn),
        .md_start (md_start),
        .len      (len),
        .num_1    (num_1),
        .num_2    (num_2),
        .modulus  (modulus),
        .md_end   (md_end),
        .mm_out   (mm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int eff_len(input logic [7:0] l);
        return (l > 8'd32) ? 32 : int'(l);
    endfunction

    // Reference: A*B*2^-k mod N via repeated modular halving; raw S is the representative in [0,2N).
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] n, input logic [7:0] l);
        longint unsigned ab;
        longint unsigned x;
        int k;
        k = eff_len(l);
        if (k == 0) return 32'd0;
        ab = a;
        ab = ab * b;
        x  = ab % n;
        for (int i = 0; i < k; i++) begin
            if (x[0]) x = x + n;
            x = x >> 1;
        end
`ifdef MONT_MULT_FINAL_SUB_EN
        return x[31:0];
`else
        if ((x << k) >= ab) return x[31:0];
        x = x + n;
        return x[31:0];
`endif
    endfunction

    // Per-cycle compare against the expectation queue.
    always @(posedge clk) begin
        logic exp_end;
        #1;
        cyc++;
        if (!rstn) begin
            q.delete();
            held = 32'd0;
            chk("rst_md_end", {63'd0, md_end}, 64'd0);
            chk("rst_mm_out", {32'd0, mm_out}, 64'd0);
        end else begin
            exp_end = (q.size() > 0) && (q[0].when == cyc);
            chk("md_end", {63'd0, md_end}, {63'd0, exp_end});
            if (exp_end) begin
                held = q[0].val;
                void'(q.pop_front());
            end
            chk("mm_out", {32'd0, mm_out}, {32'd0, held});
        end
    end

    task automatic op(input logic [7:0] l, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] n, input bit glitch);
        int k;
        k = eff_len(l);
        @(negedge clk);
        md_start = 1'b1;
        len = l; num_1 = a; num_2 = b; modulus = n;
        q.push_back('{cyc + 1 + k + 1, model(a, b, n, l)});
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            md_start = glitch && (k >= 3) && (i == 1);
            len = 8'($urandom); num_1 = $urandom; num_2 = $urandom; modulus = $urandom;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] n, a, b;
        logic [7:0]  l;

        // model pinned to hand-computed values
        chk("pin_basic", {32'd0, model(32'd5, 32'd7, 32'd13, 8'd4)}, 64'd3);
        chk("pin_ident", {32'd0, model(32'd3, 32'd7, 32'd13, 8'd4)}, 64'd7);
`ifdef MONT_MULT_FINAL_SUB_EN
        chk("pin_domain", {32'd0, model(32'd5, 32'd9, 32'd13, 8'd4)}, 64'd2);
`else
        chk("pin_domain", {32'd0, model(32'd5, 32'd9, 32'd13, 8'd4)}, 64'd15);
`endif
        chk("pin_len0", {32'd0, model(32'd5, 32'd7, 32'd13, 8'd0)}, 64'd0);

        repeat (3) @(negedge clk);
        rstn = 1'b1;

        op(8'd4, 32'd5, 32'd7, 32'd13, 1'b0);
        op(8'd4, 32'd3, 32'd7, 32'd13, 1'b0);
        op(8'd4, 32'd5, 32'd9, 32'd13, 1'b0);
        op(8'd27, 32'd67676767, 32'd52525252, 32'd128255609, 1'b0);
        op(8'd20, 32'd123457, 32'd654321, 32'd999983, 1'b1);
        op(8'd8, 32'd0, 32'd123, 32'd201, 1'b0);
        op(8'd0, 32'd5, 32'd7, 32'd13, 1'b0);
        op(8'd40, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFB, 1'b0);

        // reset mid-CALC aborts with no done pulse
        op(8'd4, 32'd5, 32'd7, 32'd13, 1'b0);
        @(negedge clk);
        md_start = 1'b1; len = 8'd16; num_1 = 32'd999; num_2 = 32'd1234; modulus = 32'd40001;
        q.push_back('{cyc + 1 + 17, model(32'd999, 32'd1234, 32'd40001, 8'd16)});
        @(negedge clk);
        md_start = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);

        // back-to-back with md_start held high
        md_start = 1'b1; len = 8'd5; num_1 = 32'd11; num_2 = 32'd17; modulus = 32'd29;
        for (int j = 0; j < 3; j++)
            q.push_back('{cyc + 1 + j * 7 + 6, model(32'd11, 32'd17, 32'd29, 8'd5)});
        repeat (15) @(negedge clk);
        md_start = 1'b0;
        repeat (6) @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(1, 32);
            n = $urandom;
            if (k < 32) n = n & ((32'd1 << k) - 32'd1);
            n = n | 32'd1;
            a = $urandom % n;
            b = $urandom % n;
            l = 8'(k);
            if ((k == 32) && ($urandom_range(0, 1) == 1)) l = 8'($urandom_range(33, 255));
            op(l, a, b, n, ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
